// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions.
// Holds the opcode[6:2] encodings, the funct3/funct7 values the legality check
// needs, the immediate format enum and the decoded-entry record stored by the
// decode stage. Imported by imm_gen, decode_stage_if and decode_stage.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // Major opcodes, inst[6:2]
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    // funct3 values that matter for legality
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    // funct7 values: base encoding and the SUB/SRA/SRAI variant
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_R
    } imm_fmt_e;

    // One fully decoded instruction as held in the main or skid entry
    typedef struct packed {
        logic [4:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1_idx;
        logic [4:0]      rs2_idx;
        logic [4:0]      rd_idx;
        logic            rd_we;
        logic            illegal;
    } dec_entry_t;

    localparam int unsigned DEC_ENTRY_W = $bits(dec_entry_t);

endpackage

// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and execute.
// Input side:  in_valid, in_ready, in_inst, in_pc (fetch -> decode).
// Output side: out_valid, out_ready and the decoded fields (decode -> execute).
// modport slave  : the decode stage itself.
// modport master : the environment (fetch + execute) driving the stage.
interface decode_stage_if;
    import riscv_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_inst;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rs1_idx;
    logic [4:0]      out_rs2_idx;
    logic [4:0]      out_rd_idx;
    logic            out_rd_we;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_funct3, out_funct7, out_imm,
               out_pc, out_rs1_idx, out_rs2_idx, out_rd_idx, out_rd_we, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_funct3, out_funct7, out_imm,
               out_pc, out_rs1_idx, out_rs2_idx, out_rd_idx, out_rd_we, out_illegal
    );

endinterface

// File: rtl/imm_gen.sv
// Combinational immediate generator.
// Ports:
//   inst  in   inst[31:2] (the two length bits are not needed here)
//   fmt   out  immediate format selected by the major opcode (FMT_R when none)
//   imm   out  sign-extended immediate; 0 for FMT_R
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:2] inst,
    output imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        unique case (inst[6:2])
            OPC_LOAD, OPC_OPIMM, OPC_JALR: fmt = FMT_I;
            OPC_STORE:                     fmt = FMT_S;
            OPC_BRANCH:                    fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:            fmt = FMT_U;
            OPC_JAL:                       fmt = FMT_J;
            default:                       fmt = FMT_R;
        endcase
    end

    always_comb begin
        unique case (fmt)
            FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm = {inst[31:12], 12'b0};
            FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction decode stage between fetch and the execute ALU.
// Decodes {inst, pc} at capture time into a dec_entry_t and holds it in a
// two-entry skid buffer (main entry drives the outputs, skid entry catches
// one more instruction) so in_ready comes straight from a flop.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   flush  in   drop all buffered and incoming instructions at the next edge
//   bus    slave modport of decode_stage_if (input handshake + decoded outputs)
module decode_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    decode_stage_if.slave    bus
);

    imm_fmt_e        fmt;
    logic [XLEN-1:0] imm;

    imm_gen u_imm_gen (
        .inst (bus.in_inst[31:2]),
        .fmt  (fmt),
        .imm  (imm)
    );

    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       legal;
    dec_entry_t new_entry;

    assign opcode = bus.in_inst[6:2];
    assign funct3 = bus.in_inst[14:12];
    assign funct7 = bus.in_inst[31:25];
    assign rd     = bus.in_inst[11:7];

    always_comb begin
        legal = (bus.in_inst[1:0] == 2'b11);
        unique case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE: ;
            OPC_OPIMM: begin
                if (funct3 == F3_SLL && funct7 != F7_BASE) begin
                    legal = 1'b0;
                end else if (funct3 == F3_SR && funct7 != F7_BASE && funct7 != F7_ALT) begin
                    legal = 1'b0;
                end
            end
            OPC_OP: begin
                // Ten ALU ops: all eight funct3 with F7_BASE, plus SUB and SRA
                if (!(funct7 == F7_BASE ||
                      (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)))) begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        new_entry         = '0;
        new_entry.opcode  = opcode;
        new_entry.funct3  = funct3;
        new_entry.funct7  = funct7;
        new_entry.imm     = legal ? imm : '0;
        new_entry.pc      = bus.in_pc;
        new_entry.rs1_idx = bus.in_inst[19:15];
        new_entry.rs2_idx = bus.in_inst[24:20];
        new_entry.rd_idx  = rd;
        // Once legal, only stores and branches lack a destination register
        new_entry.rd_we   = legal && (fmt != FMT_S) && (fmt != FMT_B) && (rd != 5'd0);
        new_entry.illegal = !legal;
    end

    dec_entry_t main_q;
    dec_entry_t skid_q;
    logic       main_valid_q;
    logic       skid_valid_q;
    logic       accept;

    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else if (flush) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!main_valid_q || bus.out_ready) begin
            if (skid_valid_q) begin
                // in_ready was low, so no new input can arrive this cycle
                main_q       <= skid_q;
                main_valid_q <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                main_valid_q <= accept;
                if (accept) begin
                    main_q <= new_entry;
                end
            end
        end else if (accept) begin
            skid_q       <= new_entry;
            skid_valid_q <= 1'b1;
        end
    end

    assign bus.in_ready    = !skid_valid_q;
    assign bus.out_valid   = main_valid_q;
    assign bus.out_opcode  = main_q.opcode;
    assign bus.out_funct3  = main_q.funct3;
    assign bus.out_funct7  = main_q.funct7;
    assign bus.out_imm     = main_q.imm;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_rs1_idx = main_q.rs1_idx;
    assign bus.out_rs2_idx = main_q.rs2_idx;
    assign bus.out_rd_idx  = main_q.rd_idx;
    assign bus.out_rd_we   = main_q.rd_we;
    assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases followed by random
// traffic, compared against a queue-based reference model.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Two's-complement sign extension of an n-bit value by plain arithmetic
    function automatic logic [31:0] sext(input logic [31:0] v, input int n);
        logic [31:0] half;
        half = 32'd1 << (n - 1);
        return (v ^ half) - half;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
        exp_t        e;
        logic [4:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        legal;
        logic        writes;
        logic [31:0] v;
        opc    = inst[6:2];
        f3     = inst[14:12];
        f7     = inst[31:25];
        legal  = (inst[1:0] == 2'b11);
        writes = 1'b0;
        e.imm  = 32'd0;
        case (opc)
            5'b00000, 5'b11001: begin
                e.imm = sext(32'(inst[31:20]), 12); writes = 1'b1;
            end
            5'b00100: begin
                e.imm = sext(32'(inst[31:20]), 12); writes = 1'b1;
                if (f3 == 3'd1 && f7 != 7'd0) legal = 1'b0;
                if (f3 == 3'd5 && f7 != 7'd0 && f7 != 7'd32) legal = 1'b0;
            end
            5'b01000: begin
                v = 32'(inst[31:25]) * 32 + 32'(inst[11:7]);
                e.imm = sext(v, 12);
            end
            5'b11000: begin
                v = 32'(inst[31]) * 4096 + 32'(inst[7]) * 2048 + 32'(inst[30:25]) * 32
                    + 32'(inst[11:8]) * 2;
                e.imm = sext(v, 13);
            end
            5'b01101, 5'b00101: begin
                e.imm = inst & 32'hFFFF_F000; writes = 1'b1;
            end
            5'b11011: begin
                v = 32'(inst[31]) * (1 << 20) + 32'(inst[19:12]) * (1 << 12)
                    + 32'(inst[20]) * (1 << 11) + 32'(inst[30:21]) * 2;
                e.imm = sext(v, 21); writes = 1'b1;
            end
            5'b01100: begin
                writes = 1'b1;
                if (!(f7 == 7'd0 || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5)))) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            e.imm  = 32'd0;
            writes = 1'b0;
        end
        e.inst = inst;
        e.pc   = pc;
        e.ill  = !legal;
        e.we   = writes && (inst[11:7] != 5'd0);
        return e;
    endfunction

    task automatic check_outputs();
        exp_t e;
        check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            e = q[0];
            check("opcode", 32'(bus.out_opcode), 32'(e.inst[6:2]));
            check("funct3", 32'(bus.out_funct3), 32'(e.inst[14:12]));
            check("funct7", 32'(bus.out_funct7), 32'(e.inst[31:25]));
            check("rs1", 32'(bus.out_rs1_idx), 32'(e.inst[19:15]));
            check("rs2", 32'(bus.out_rs2_idx), 32'(e.inst[24:20]));
            check("rd", 32'(bus.out_rd_idx), 32'(e.inst[11:7]));
            check("imm", bus.out_imm, e.imm);
            check("pc", bus.out_pc, e.pc);
            check("rd_we", 32'(bus.out_rd_we), 32'(e.we));
            check("illegal", 32'(bus.out_illegal), 32'(e.ill));
        end
    endtask

    // One clock: drive after the falling edge, check, advance model at the rising edge
    task automatic cycle(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        logic fire_in;
        logic fire_out;
        bus.in_valid  = iv;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        check_outputs();
        fire_in  = iv && (q.size() < 2);
        fire_out = ordy && (q.size() > 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (fire_out) void'(q.pop_front());
            if (fire_in) q.push_back(ref_decode(inst, pc));
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  opcs [9];
        logic [31:0] w;
        int          k;
        opcs = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                 5'b01101, 5'b11000, 5'b11001, 5'b11011};
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) w[6:2] = opcs[k];
        if ($urandom_range(0, 9) != 0) w[1:0] = 2'b11;
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'd0;
            1: w[31:25] = 7'd32;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = 32'd0;
        bus.in_pc     = 32'd0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst in_ready", 32'(bus.in_ready), 32'd1);
        check("rst imm", bus.out_imm, 32'd0);
        check("rst pc", bus.out_pc, 32'd0);
        check("rst fields", {bus.out_opcode, bus.out_funct3, bus.out_funct7, bus.out_rs1_idx,
                             bus.out_rs2_idx, bus.out_rd_idx, bus.out_rd_we, bus.out_illegal},
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // addi x1,x0,-1
        cycle(1'b1, 32'hFFF00093, 32'h0, 1'b1, 1'b0);
        check("addi valid", 32'(bus.out_valid), 32'd1);
        check("addi opcode", 32'(bus.out_opcode), 32'h04);
        check("addi imm", bus.out_imm, 32'hFFFF_FFFF);
        check("addi rd_we", 32'(bus.out_rd_we), 32'd1);
        // lui x5,0x12345 then sw x2,8(x1)
        cycle(1'b1, 32'h123452B7, 32'h4, 1'b1, 1'b0);
        check("lui imm", bus.out_imm, 32'h1234_5000);
        check("lui rd", 32'(bus.out_rd_idx), 32'd5);
        cycle(1'b1, 32'h0020A423, 32'h8, 1'b1, 1'b0);
        check("sw imm", bus.out_imm, 32'd8);
        check("sw rd_we", 32'(bus.out_rd_we), 32'd0);
        // beq x0,x0,-4 at 0x100
        cycle(1'b1, 32'hFE000EE3, 32'h100, 1'b1, 1'b0);
        check("beq imm", bus.out_imm, 32'hFFFF_FFFC);
        check("beq pc", bus.out_pc, 32'h100);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: three offers, only two fit
        cycle(1'b1, 32'h00100113, 32'h200, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200193, 32'h204, 1'b0, 1'b0);
        check("bp in_ready", 32'(bus.in_ready), 32'd0);
        cycle(1'b1, 32'h00300213, 32'h208, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300213, 32'h208, 1'b1, 1'b0);
        cycle(1'b1, 32'h00300213, 32'h208, 1'b1, 1'b0);
        check("bp third pc", bus.out_pc, 32'h208);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Illegal encodings and a legal srai
        cycle(1'b1, 32'h00000000, 32'h300, 1'b1, 1'b0);
        check("zero illegal", 32'(bus.out_illegal), 32'd1);
        cycle(1'b1, 32'h40001013, 32'h304, 1'b1, 1'b0);
        check("slli alt illegal", 32'(bus.out_illegal), 32'd1);
        check("slli alt rd_we", 32'(bus.out_rd_we), 32'd0);
        cycle(1'b1, 32'h40105093, 32'h308, 1'b1, 1'b0);
        check("srai legal", 32'(bus.out_illegal), 32'd0);
        check("srai funct7", 32'(bus.out_funct7), 32'h20);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with both entries full and an input offered
        cycle(1'b1, 32'h00500293, 32'h400, 1'b0, 1'b0);
        cycle(1'b1, 32'h00600313, 32'h404, 1'b0, 1'b0);
        cycle(1'b1, 32'h00700393, 32'h408, 1'b0, 1'b1);
        check("flush out_valid", 32'(bus.out_valid), 32'd0);
        check("flush in_ready", 32'(bus.in_ready), 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream
        cycle(1'b1, 32'h00800413, 32'h500, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst in_ready", 32'(bus.in_ready), 32'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) < 7), rand_inst(), $urandom,
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
